// File: rtl/fp32_alu.sv
// Purpose: single-precision add/sub/mul/div ALU, truncating, denormals flushed to zero.
// Latency: 1 cycle, operands sampled on the rising edge, outputs registered and held.
// Backpressure: none; a new operation may be issued every cycle.
// Build option: define ALU_DIV_EN to include the divider, otherwise opcode 011 is reserved.
module fp32_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  operation,
    output logic [31:0] Result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);
    localparam logic [2:0]  OP_ADD = 3'b000;
    localparam logic [2:0]  OP_SUB = 3'b001;
    localparam logic [2:0]  OP_MUL = 3'b010;
    localparam logic [2:0]  OP_DIV = 3'b011;
    localparam logic [31:0] QNAN   = 32'h7FC00000;
`ifdef ALU_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    // Operand fields; exponent 0 means zero (denormals flushed), 255 means NaN/Inf.
    logic        sa, sb, sbe, za, zb, ia, ib;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    assign sa  = A[31];
    assign sb  = B[31];
    assign sbe = sb ^ (operation == OP_SUB);
    assign ea  = A[30:23];
    assign eb  = B[30:23];
    assign za  = (ea == 8'd0);
    assign zb  = (eb == 8'd0);
    assign ia  = (ea == 8'hFF);
    assign ib  = (eb == 8'hFF);
    assign ma  = {1'b1, A[22:0]};
    assign mb  = {1'b1, B[22:0]};

    // Returns the left shift that brings the leading 1 of v to bit 23.
    function automatic logic [4:0] lzc(input logic [23:0] v);
        lzc = 5'd0;
        for (int i = 0; i < 24; i++)
            if (v[i]) lzc = 5'(23 - i);
    endfunction

    logic               s_big, add_s, add_z;
    logic [7:0]         e_big, e_sml, e_dif;
    logic [23:0]        m_big, m_sml, m_aln, m_dif, add_m;
    logic [24:0]        m_sum;
    logic [4:0]         lz;
    logic signed [9:0]  add_e;

    // Add/sub: order by magnitude, align the smaller operand, then add or subtract and normalize.
    always_comb begin
        if ({eb, mb} > {ea, ma}) begin
            e_big = eb; m_big = mb; s_big = sbe;
            e_sml = ea; m_sml = ma;
        end else begin
            e_big = ea; m_big = ma; s_big = sa;
            e_sml = eb; m_sml = mb;
        end
        e_dif = e_big - e_sml;
        m_aln = (e_dif > 8'd23) ? 24'd0 : (m_sml >> e_dif);
        m_sum = {1'b0, m_big} + {1'b0, m_aln};
        m_dif = m_big - m_aln;
        lz    = lzc(m_dif);
        add_s = s_big;
        add_z = 1'b0;
        add_m = 24'd0;
        add_e = 10'sd0;
        if (sa == sbe) begin
            if (m_sum[24]) begin
                add_m = m_sum[24:1];
                add_e = $signed({2'b00, e_big}) + 10'sd1;
            end else begin
                add_m = m_sum[23:0];
                add_e = $signed({2'b00, e_big});
            end
        end else if (m_dif == 24'd0) begin
            // Exact cancellation always yields +0.
            add_z = 1'b1;
            add_s = 1'b0;
        end else begin
            add_m = m_dif << lz;
            add_e = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
        end
    end

    logic [47:0]       prod;
    logic [23:0]       mul_m;
    logic signed [9:0] mul_e;

    // Mul: full 24x24 product, keep the top 24 significant bits.
    always_comb begin
        prod  = ma * mb;
        mul_m = prod[47] ? prod[47:24] : prod[46:23];
        mul_e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
              + (prod[47] ? 10'sd1 : 10'sd0);
    end

`ifdef ALU_DIV_EN
    logic [24:0]       rem;
    logic [23:0]       quo, div_m;
    logic signed [9:0] div_e;

    // Div: restoring divider producing floor((mA<<23)/mB); mA < 2*mB so 24 quotient bits suffice.
    always_comb begin
        rem = {1'b0, ma};
        quo = 24'd0;
        for (int i = 23; i >= 0; i--) begin
            if (rem >= {1'b0, mb}) begin
                quo[i] = 1'b1;
                rem    = rem - {1'b0, mb};
            end
            rem = {rem[23:0], 1'b0};
        end
        div_e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        div_m = quo;
        if (!quo[23]) begin
            div_m = {quo[22:0], 1'b0};
            div_e = div_e - 10'sd1;
        end
    end
`endif

    logic [31:0]       nxt_res;
    logic              nxt_exc, nxt_ovf, nxt_unf, use_norm, s_r;
    logic signed [9:0] e_r;
    logic [23:0]       m_r;

    // Result select: exceptions first, then operand-zero shortcuts, then range check of the normal path.
    always_comb begin
        nxt_res  = 32'd0;
        nxt_exc  = 1'b0;
        nxt_ovf  = 1'b0;
        nxt_unf  = 1'b0;
        use_norm = 1'b0;
        s_r      = 1'b0;
        e_r      = 10'sd0;
        m_r      = 24'd0;
        if (ia || ib || operation[2] || (operation == OP_DIV && (!DIV_EN || zb))) begin
            nxt_exc = 1'b1;
            nxt_res = QNAN;
        end else begin
            case (operation)
                OP_ADD, OP_SUB: begin
                    if (zb)         nxt_res = {sa, za ? 31'd0 : A[30:0]};
                    else if (za)    nxt_res = {sbe, B[30:0]};
                    else if (add_z) nxt_res = 32'd0;
                    else begin
                        use_norm = 1'b1;
                        s_r = add_s; e_r = add_e; m_r = add_m;
                    end
                end
                OP_MUL: begin
                    if (za || zb) nxt_res = {sa ^ sb, 31'd0};
                    else begin
                        use_norm = 1'b1;
                        s_r = sa ^ sb; e_r = mul_e; m_r = mul_m;
                    end
                end
`ifdef ALU_DIV_EN
                OP_DIV: begin
                    if (za) nxt_res = {sa ^ sb, 31'd0};
                    else begin
                        use_norm = 1'b1;
                        s_r = sa ^ sb; e_r = div_e; m_r = div_m;
                    end
                end
`endif
                default: nxt_res = QNAN;
            endcase
            if (use_norm) begin
                if (e_r > 10'sd254) begin
                    nxt_ovf = 1'b1;
                    nxt_res = {s_r, 8'hFF, 23'd0};
                end else if (e_r < 10'sd1) begin
                    nxt_unf = 1'b1;
                    nxt_res = {s_r, 31'd0};
                end else begin
                    nxt_res = {s_r, e_r[7:0], m_r[22:0]};
                end
            end
        end
    end

    // Bits discarded by truncation and the implicit leading one.
    logic unused_bits;
    assign unused_bits = ^{prod[22:0], m_r[23]};

    // Output register; reset clears it asynchronously and holds it clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result    <= 32'd0;
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Result    <= nxt_res;
            Exception <= nxt_exc;
            Overflow  <= nxt_ovf;
            Underflow <= nxt_unf;
        end
    end
endmodule

// File: tb/tb_fp32_alu.sv
// Purpose: directed-vector scoreboard bench for fp32_alu, including async reset behaviour.
// Latency: expects each result one rising edge after its operands are driven.
// Backpressure: none; vectors are issued back to back, one per cycle.
module tb_fp32_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B, Result;
    logic [2:0]  operation;
    logic        Exception, Overflow, Underflow;

    int checks   = 0;
    int failures = 0;
    int vec_id   = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic        ovf;
        logic        unf;
        int          id;
    } exp_t;
    exp_t sbq[$];

    fp32_alu dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .operation (operation),
        .Result    (Result),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [34:0] got, input logic [34:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got res=%h exc=%b ovf=%b unf=%b, want res=%h exc=%b ovf=%b unf=%b",
                     name, got[34:3], got[2], got[1], got[0], want[34:3], want[2], want[1], want[0]);
        end
    endtask

    // Drive operands now and queue the response expected after the next rising edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] er, input logic ee, input logic eo, input logic eu);
        exp_t e;
        A = a; B = b; operation = op;
        e.res = er; e.exc = ee; e.ovf = eo; e.unf = eu; e.id = vec_id;
        sbq.push_back(e);
        vec_id++;
    endtask

    task automatic vec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] er, input logic ee, input logic eo, input logic eu);
        @(negedge clk);
        drive(a, b, op, er, ee, eo, eu);
    endtask

    // Monitor: after every rising edge, compare outputs against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("vec%0d", e.id), {Result, Exception, Overflow, Underflow},
                    {e.res, e.exc, e.ovf, e.unf});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; A = 32'h411CCCCD; B = 32'h4089999A; operation = 3'b000;
        #12;
        chk("reset_state", {Result, Exception, Overflow, Underflow}, 35'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_no_edge", {Result, Exception, Overflow, Underflow}, 35'd0);

        vec(32'h411CCCCD, 32'h4089999A, 3'b000, 32'h4161999A, 0, 0, 0);
        vec(32'h411CCCCD, 32'h4089999A, 3'b001, 32'h40B00000, 0, 0, 0);
        vec(32'h411CCCCD, 32'h4089999A, 3'b010, 32'h42288F5C, 0, 0, 0);
`ifdef ALU_DIV_EN
        vec(32'h411CCCCD, 32'h4089999A, 3'b011, 32'h4011DC47, 0, 0, 0);
        vec(32'h3F800000, 32'h3FC00000, 3'b011, 32'h3F2AAAAA, 0, 0, 0);
        vec(32'h00000000, 32'hC0000000, 3'b011, 32'h80000000, 0, 0, 0);
`else
        vec(32'h411CCCCD, 32'h4089999A, 3'b011, 32'h7FC00000, 1, 0, 0);
        vec(32'h3F800000, 32'h3FC00000, 3'b011, 32'h7FC00000, 1, 0, 0);
`endif
        vec(32'h7F000000, 32'h7F000000, 3'b010, 32'h7F800000, 0, 1, 0);
        vec(32'h00800000, 32'h00800000, 3'b010, 32'h00000000, 0, 0, 1);
        vec(32'h3F800000, 32'h00000000, 3'b011, 32'h7FC00000, 1, 0, 0);
        vec(32'h3F800000, 32'h3F800000, 3'b100, 32'h7FC00000, 1, 0, 0);
        vec(32'h7F800000, 32'h3F800000, 3'b000, 32'h7FC00000, 1, 0, 0);
        vec(32'h411CCCCD, 32'h00000000, 3'b000, 32'h411CCCCD, 0, 0, 0);
        vec(32'h00000000, 32'hC0000000, 3'b010, 32'h80000000, 0, 0, 0);
        vec(32'h3F800000, 32'h3F800000, 3'b001, 32'h00000000, 0, 0, 0);
        vec(32'h3FC00000, 32'h3FC00000, 3'b000, 32'h40400000, 0, 0, 0);
        vec(32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 32'h7F800000, 0, 1, 0);
        vec(32'h00000001, 32'h3F800000, 3'b000, 32'h3F800000, 0, 0, 0);
        vec(32'hC0000000, 32'h40400000, 3'b010, 32'hC0C00000, 0, 0, 0);
        vec(32'h00800001, 32'h00800000, 3'b001, 32'h00000000, 0, 0, 1);
        vec(32'h3F800000, 32'h3F400000, 3'b001, 32'h3E800000, 0, 0, 0);

        // Mid-stream reset with an add in flight.
        vec(32'h411CCCCD, 32'h4089999A, 3'b000, 32'h4161999A, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_clear", {Result, Exception, Overflow, Underflow}, 35'd0);
        @(posedge clk);
        #1;
        chk("rst_inputs_discarded", {Result, Exception, Overflow, Underflow}, 35'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h411CCCCD, 32'h4089999A, 3'b001, 32'h40B00000, 0, 0, 0);
        #1;
        chk("rst_release_wait_edge", {Result, Exception, Overflow, Underflow}, 35'd0);

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending results, want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
